// File: rtl/proc_ctrl_seq.sv
// ---------------------------------------------------------------------------
// proc_ctrl_seq
//   Control unit for the simple bus-based processor. An internal step FSM
//   (T0..T3) walks each instruction through fetch and execute. An internal
//   IR latch captures the instruction word. The unit drives the bus mux,
//   the register-file enables, the A/G registers and the ALU of the datapath.
//   It also flags undefined opcodes and counts retired instructions.
//
//   Parameters
//     DATA_W    bus / instruction width (>= 3 + 2*RSEL_W)
//     REG_NUM   number of general registers (power of 2, >= 2)
//     RSEL_W    register-select field width
//     CNT_W     retired-instruction counter width
//
//   Ports
//     clk        system clock
//     resetn     asynchronous reset, active low
//     run        start request, sampled only in T0
//     DIN        instruction word (T0) / immediate (T1 of MVI)
//     G_nz       datapath G register is non-zero
//     done       last cycle of the current instruction
//     IR         latched instruction
//     Tstep      current step, 0..3
//     IRin       IR load strobe
//     Ain, Gin   A / G register load enables
//     alu_op     00 add, 01 sub, 10 and
//     Rin        one-hot register load enables
//     Rout       one-hot register bus drive
//     Gout       G register bus drive
//     DINout     DIN bus drive
//     illegal    sticky flag: an undefined opcode was executed
//     instr_cnt  count of retired instructions (wraps)
// ---------------------------------------------------------------------------
module proc_ctrl_seq #(
  parameter int DATA_W  = 9,
  parameter int REG_NUM = 8,
  parameter int RSEL_W  = $clog2(REG_NUM),
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               run,
  input  logic [DATA_W-1:0]  DIN,
  input  logic               G_nz,
  output logic               done,
  output logic [DATA_W-1:0]  IR,
  output logic [1:0]         Tstep,
  output logic               IRin,
  output logic               Ain,
  output logic               Gin,
  output logic [1:0]         alu_op,
  output logic [REG_NUM-1:0] Rin,
  output logic [REG_NUM-1:0] Rout,
  output logic               Gout,
  output logic               DINout,
  output logic               illegal,
  output logic [CNT_W-1:0]   instr_cnt
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } step_t;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MVNZ = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  step_t              state, state_nxt;
  logic [DATA_W-1:0]  ir_q;
  logic               illegal_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [2:0]          op;
  logic [RSEL_W-1:0]   xsel, ysel;
  logic [REG_NUM-1:0]  xdec, ydec;
  logic                is_alu;
  logic [1:0]          alu_sel;

  // Raw (ungated) strobes from the step decode.
  logic               done_c, irin_c, ain_c, gin_c, gout_c, dinout_c;
  logic [1:0]         aluop_c;
  logic [REG_NUM-1:0] rin_c, rout_c;
  logic               set_illegal;

  function automatic logic [REG_NUM-1:0] onehot(input logic [RSEL_W-1:0] sel);
    logic [REG_NUM-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

  // Instruction field decode.
  assign op   = ir_q[2*RSEL_W+2 -: 3];
  assign xsel = ir_q[2*RSEL_W-1:RSEL_W];
  assign ysel = ir_q[RSEL_W-1:0];
  assign xdec = onehot(xsel);
  assign ydec = onehot(ysel);

  always_comb begin
    is_alu  = 1'b0;
    alu_sel = ALU_ADD;
    case (op)
      OP_ADD: begin is_alu = 1'b1; alu_sel = ALU_ADD; end
      OP_SUB: begin is_alu = 1'b1; alu_sel = ALU_SUB; end
      OP_AND: begin is_alu = 1'b1; alu_sel = ALU_AND; end
      default: begin is_alu = 1'b0; alu_sel = ALU_ADD; end
    endcase
  end

  // Step FSM register plus IR latch, sticky illegal flag and retire counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= T0;
      ir_q      <= '0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state <= state_nxt;
      if (irin_c)
        ir_q <= DIN;
      if (set_illegal)
        illegal_q <= 1'b1;
      if (done_c)
        cnt_q <= cnt_q + CNT_ONE;
    end
  end

  // Next-step and strobe decode from (state, IR, G_nz, run).
  always_comb begin
    state_nxt   = state;
    done_c      = 1'b0;
    irin_c      = 1'b0;
    ain_c       = 1'b0;
    gin_c       = 1'b0;
    gout_c      = 1'b0;
    dinout_c    = 1'b0;
    aluop_c     = ALU_ADD;
    rin_c       = '0;
    rout_c      = '0;
    set_illegal = 1'b0;

    case (state)
      T0: begin
        if (run) begin
          irin_c    = 1'b1;
          state_nxt = T1;
        end
      end

      T1: begin
        state_nxt = T0;
        case (op)
          OP_MV: begin
            rout_c = ydec;
            rin_c  = xdec;
            done_c = 1'b1;
          end
          OP_MVI: begin
            dinout_c = 1'b1;
            rin_c    = xdec;
            done_c   = 1'b1;
          end
          OP_MVNZ: begin
            done_c = 1'b1;
            // Not-taken still drives nothing onto the bus, so no write occurs.
            if (G_nz) begin
              rout_c = ydec;
              rin_c  = xdec;
            end
          end
          OP_ADD, OP_SUB, OP_AND: begin
            rout_c    = xdec;
            ain_c     = 1'b1;
            state_nxt = T2;
          end
          default: begin
            done_c      = 1'b1;
            set_illegal = 1'b1;
          end
        endcase
      end

      T2: begin
        // Only ALU instructions reach T2; anything else falls back to fetch.
        if (is_alu) begin
          rout_c    = ydec;
          gin_c     = 1'b1;
          aluop_c   = alu_sel;
          state_nxt = T3;
        end else begin
          state_nxt = T0;
        end
      end

      T3: begin
        state_nxt = T0;
        if (is_alu) begin
          gout_c  = 1'b1;
          rin_c   = xdec;
          done_c  = 1'b1;
          aluop_c = alu_sel;
        end
      end

      default: state_nxt = T0;
    endcase
  end

  // Strobes are held low for as long as reset is asserted, independent of
  // the step register, so that a mid-instruction reset kills writes at once.
  assign done      = resetn & done_c;
  assign IRin      = resetn & irin_c;
  assign Ain       = resetn & ain_c;
  assign Gin       = resetn & gin_c;
  assign Gout      = resetn & gout_c;
  assign DINout    = resetn & dinout_c;
  assign alu_op    = resetn ? aluop_c : ALU_ADD;
  assign Rin       = resetn ? rin_c   : '0;
  assign Rout      = resetn ? rout_c  : '0;

  assign IR        = ir_q;
  assign Tstep     = state;
  assign illegal   = illegal_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_proc_ctrl_seq.sv
module tb_proc_ctrl_seq;

  localparam int DATA_W  = 9;
  localparam int REG_NUM = 8;
  localparam int CNT_W   = 4;

  logic               clk;
  logic               resetn;
  logic               run;
  logic [DATA_W-1:0]  DIN;
  logic               G_nz;
  logic               done;
  logic [DATA_W-1:0]  IR;
  logic [1:0]         Tstep;
  logic               IRin;
  logic               Ain;
  logic               Gin;
  logic [1:0]         alu_op;
  logic [REG_NUM-1:0] Rin;
  logic [REG_NUM-1:0] Rout;
  logic               Gout;
  logic               DINout;
  logic               illegal;
  logic [CNT_W-1:0]   instr_cnt;

  int checks = 0;
  int errors = 0;

  proc_ctrl_seq #(
    .DATA_W (DATA_W),
    .REG_NUM(REG_NUM),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .run      (run),
    .DIN      (DIN),
    .G_nz     (G_nz),
    .done     (done),
    .IR       (IR),
    .Tstep    (Tstep),
    .IRin     (IRin),
    .Ain      (Ain),
    .Gin      (Gin),
    .alu_op   (alu_op),
    .Rin      (Rin),
    .Rout     (Rout),
    .Gout     (Gout),
    .DINout   (DINout),
    .illegal  (illegal),
    .instr_cnt(instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Apply inputs on the falling edge and let the decode settle.
  task automatic cyc(input logic r, input logic [DATA_W-1:0] d, input logic g);
    @(negedge clk);
    run  = r;
    DIN  = d;
    G_nz = g;
    #1;
  endtask

  task automatic exp_s(input string tag, input logic [1:0] t, input logic d,
                       input logic irin, input logic ain, input logic gin,
                       input logic [1:0] op, input logic [7:0] rin,
                       input logic [7:0] rout, input logic gout, input logic dinout);
    chk({tag, ".Tstep"},  32'(Tstep),  32'(t));
    chk({tag, ".done"},   32'(done),   32'(d));
    chk({tag, ".IRin"},   32'(IRin),   32'(irin));
    chk({tag, ".Ain"},    32'(Ain),    32'(ain));
    chk({tag, ".Gin"},    32'(Gin),    32'(gin));
    chk({tag, ".alu_op"}, 32'(alu_op), 32'(op));
    chk({tag, ".Rin"},    32'(Rin),    32'(rin));
    chk({tag, ".Rout"},   32'(Rout),   32'(rout));
    chk({tag, ".Gout"},   32'(Gout),   32'(gout));
    chk({tag, ".DINout"}, 32'(DINout), 32'(dinout));
  endtask

  initial begin
    resetn = 1'b0;
    run    = 1'b1;
    DIN    = 9'b001_011_000;
    G_nz   = 1'b0;

    // Reset held with run=1: everything quiet.
    repeat (2) @(negedge clk);
    #1;
    exp_s("rst", 2'd0, 0, 0, 0, 0, 2'b00, 8'h00, 8'h00, 0, 0);
    chk("rst.IR", 32'(IR), 32'h0);
    chk("rst.illegal", 32'(illegal), 32'h0);
    chk("rst.cnt", 32'(instr_cnt), 32'h0);

    // 1. MVI R3
    @(negedge clk);
    resetn = 1'b1;
    #1;
    exp_s("mvi.t0", 2'd0, 0, 1, 0, 0, 2'b00, 8'h00, 8'h00, 0, 0);
    cyc(0, 9'b001_011_000, 0);
    chk("mvi.IR", 32'(IR), 32'h058);
    exp_s("mvi.t1", 2'd1, 1, 0, 0, 0, 2'b00, 8'h08, 8'h00, 0, 1);
    cyc(0, 9'h000, 0);
    exp_s("mvi.idle", 2'd0, 0, 0, 0, 0, 2'b00, 8'h00, 8'h00, 0, 0);
    chk("mvi.cnt", 32'(instr_cnt), 32'd1);

    // 2. ADD R1,R2 then SUB R1,R2
    cyc(1, 9'b010_001_010, 0);
    exp_s("add.t0", 2'd0, 0, 1, 0, 0, 2'b00, 8'h00, 8'h00, 0, 0);
    cyc(0, 9'h000, 0);
    exp_s("add.t1", 2'd1, 0, 0, 1, 0, 2'b00, 8'h00, 8'h02, 0, 0);
    cyc(0, 9'h000, 0);
    exp_s("add.t2", 2'd2, 0, 0, 0, 1, 2'b00, 8'h00, 8'h04, 0, 0);
    cyc(0, 9'h000, 0);
    exp_s("add.t3", 2'd3, 1, 0, 0, 0, 2'b00, 8'h02, 8'h00, 1, 0);
    cyc(1, 9'b011_001_010, 0);
    exp_s("sub.t0", 2'd0, 0, 1, 0, 0, 2'b00, 8'h00, 8'h00, 0, 0);
    chk("add.cnt", 32'(instr_cnt), 32'd2);
    cyc(0, 9'h000, 0);
    exp_s("sub.t1", 2'd1, 0, 0, 1, 0, 2'b00, 8'h00, 8'h02, 0, 0);
    cyc(0, 9'h000, 0);
    exp_s("sub.t2", 2'd2, 0, 0, 0, 1, 2'b01, 8'h00, 8'h04, 0, 0);
    cyc(0, 9'h000, 0);
    exp_s("sub.t3", 2'd3, 1, 0, 0, 0, 2'b01, 8'h02, 8'h00, 1, 0);

    // 3. MVNZ R5,R0 not taken, then taken
    cyc(1, 9'b100_101_000, 0);
    chk("sub.cnt", 32'(instr_cnt), 32'd3);
    cyc(0, 9'h000, 0);
    exp_s("mvnz0.t1", 2'd1, 1, 0, 0, 0, 2'b00, 8'h00, 8'h00, 0, 0);
    cyc(1, 9'b100_101_000, 1);
    cyc(0, 9'h000, 1);
    exp_s("mvnz1.t1", 2'd1, 1, 0, 0, 0, 2'b00, 8'h20, 8'h01, 0, 0);

    // 4. Illegal opcode, sticky across later valid instructions
    cyc(1, 9'b110_000_000, 0);
    chk("mvnz.cnt", 32'(instr_cnt), 32'd5);
    cyc(0, 9'h000, 0);
    exp_s("ill.t1", 2'd1, 1, 0, 0, 0, 2'b00, 8'h00, 8'h00, 0, 0);
    chk("ill.before", 32'(illegal), 32'h0);
    cyc(1, 9'b000_010_011, 0);
    chk("ill.set", 32'(illegal), 32'h1);
    chk("ill.cnt", 32'(instr_cnt), 32'd6);
    cyc(0, 9'h000, 0);
    exp_s("mv.t1", 2'd1, 1, 0, 0, 0, 2'b00, 8'h04, 8'h08, 0, 0);
    cyc(1, 9'b000_110_110, 0);
    chk("ill.sticky", 32'(illegal), 32'h1);
    cyc(0, 9'h000, 0);
    exp_s("mvxx.t1", 2'd1, 1, 0, 0, 0, 2'b00, 8'h40, 8'h40, 0, 0);

    // 5. AND R4,R7 with a one-cycle run pulse
    cyc(1, 9'b101_100_111, 0);
    exp_s("and.t0", 2'd0, 0, 1, 0, 0, 2'b00, 8'h00, 8'h00, 0, 0);
    cyc(0, 9'h000, 0);
    exp_s("and.t1", 2'd1, 0, 0, 1, 0, 2'b00, 8'h00, 8'h10, 0, 0);
    cyc(0, 9'h000, 0);
    exp_s("and.t2", 2'd2, 0, 0, 0, 1, 2'b10, 8'h00, 8'h80, 0, 0);
    cyc(0, 9'h000, 0);
    exp_s("and.t3", 2'd3, 1, 0, 0, 0, 2'b10, 8'h10, 8'h00, 1, 0);
    cyc(0, 9'h000, 0);
    exp_s("and.idle1", 2'd0, 0, 0, 0, 0, 2'b00, 8'h00, 8'h00, 0, 0);
    cyc(0, 9'h000, 0);
    exp_s("and.idle2", 2'd0, 0, 0, 0, 0, 2'b00, 8'h00, 8'h00, 0, 0);
    chk("and.cnt", 32'(instr_cnt), 32'd9);

    // Reset asserted in T2 of another AND
    cyc(1, 9'b101_100_111, 0);
    cyc(0, 9'h000, 0);
    cyc(0, 9'h000, 0);
    exp_s("and2.t2", 2'd2, 0, 0, 0, 1, 2'b10, 8'h00, 8'h80, 0, 0);
    resetn = 1'b0;
    #1;
    exp_s("midrst", 2'd0, 0, 0, 0, 0, 2'b00, 8'h00, 8'h00, 0, 0);
    chk("midrst.illegal", 32'(illegal), 32'h0);
    chk("midrst.cnt", 32'(instr_cnt), 32'h0);
    chk("midrst.IR", 32'(IR), 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    cyc(0, 9'h000, 0);
    exp_s("postrst", 2'd0, 0, 0, 0, 0, 2'b00, 8'h00, 8'h00, 0, 0);

    // 6. run held high across MVI R1; ADD R1,R1; MV R0,R1
    cyc(1, 9'b001_001_000, 0);
    exp_s("b2b.c0", 2'd0, 0, 1, 0, 0, 2'b00, 8'h00, 8'h00, 0, 0);
    cyc(1, 9'b001_001_000, 0);
    exp_s("b2b.c1", 2'd1, 1, 0, 0, 0, 2'b00, 8'h02, 8'h00, 0, 1);
    cyc(1, 9'b010_001_001, 0);
    exp_s("b2b.c2", 2'd0, 0, 1, 0, 0, 2'b00, 8'h00, 8'h00, 0, 0);
    cyc(1, 9'h000, 0);
    exp_s("b2b.c3", 2'd1, 0, 0, 1, 0, 2'b00, 8'h00, 8'h02, 0, 0);
    cyc(1, 9'h000, 0);
    exp_s("b2b.c4", 2'd2, 0, 0, 0, 1, 2'b00, 8'h00, 8'h02, 0, 0);
    cyc(1, 9'h000, 0);
    exp_s("b2b.c5", 2'd3, 1, 0, 0, 0, 2'b00, 8'h02, 8'h00, 1, 0);
    cyc(1, 9'b000_000_001, 0);
    exp_s("b2b.c6", 2'd0, 0, 1, 0, 0, 2'b00, 8'h00, 8'h00, 0, 0);
    cyc(1, 9'h000, 0);
    exp_s("b2b.c7", 2'd1, 1, 0, 0, 0, 2'b00, 8'h01, 8'h02, 0, 0);

    // Counter wrap: 12 more instructions reach all-ones, one more wraps.
    for (int i = 0; i < 12; i++) begin
      cyc(1, 9'b000_000_001, 0);
      cyc(1, 9'h000, 0);
    end
    cyc(0, 9'h000, 0);
    chk("cnt.max", 32'(instr_cnt), 32'd15);
    cyc(1, 9'b000_000_001, 0);
    cyc(0, 9'h000, 0);
    cyc(0, 9'h000, 0);
    chk("cnt.wrap", 32'(instr_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
